// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: issues single outstanding requests to the
// instruction TIM and queues returned words with their PCs for decode.
// Handles redirects and fence.i, including the TIM invalidate sweep.

package fetch_buffer_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned buffer_depth = 4,
  parameter logic [31:0] start_addr   = 32'h0,
  parameter int unsigned itim_depth   = 64,
  parameter int unsigned fence_cycles = itim_depth + 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  input  logic        fence_valid,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data,
  output mem_in_type  itim_in,
  input  mem_out_type itim_out
);

  localparam int unsigned PW = $clog2(buffer_depth);
  localparam int unsigned CW = $clog2(buffer_depth + 1);
  localparam int unsigned FW = $clog2(fence_cycles + 1);

  typedef enum logic [1:0] {
    RUN,
    FENCE_DRAIN,
    FENCE_WAIT
  } state_t;

  state_t          state, state_n;
  logic [31:0]     pc, pc_n;
  logic [31:0]     req_pc, req_pc_n;
  logic            pending, pending_n;
  logic            drop, drop_n;
  logic [FW-1:0]   fcnt, fcnt_n;
  logic [PW-1:0]   wptr, wptr_n;
  logic [PW-1:0]   rptr, rptr_n;
  logic [CW-1:0]   count, count_n;
  logic            mem_valid_q, mem_fence_q;
  logic [31:0]     mem_addr_q;

  logic            resp, pop, push, flush, fence_take;
  logic            issue, issue_fence;

  logic [31:0]     buf_pc   [buffer_depth];
  logic [31:0]     buf_data [buffer_depth];

  // Next-state, FIFO pointer and issue decisions for the whole stage.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_pc_n    = req_pc;
    pending_n   = pending;
    drop_n      = drop;
    fcnt_n      = fcnt;
    wptr_n      = wptr;
    rptr_n      = rptr;
    count_n     = count;
    issue       = 1'b0;
    issue_fence = 1'b0;

    resp       = pending && itim_out.mem_ready;
    pop        = instr_valid && instr_ready;
    fence_take = (state == RUN) && fence_valid;
    flush      = jump_valid || fence_take;
    push       = resp && !drop && !flush && (state == RUN);

    if (resp) begin
      pending_n = 1'b0;
      drop_n    = 1'b0;
    end

    // A flush with a request still in flight marks its late response for discard.
    if (flush) begin
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
      if (pending && !itim_out.mem_ready) drop_n = 1'b1;
    end else begin
      if (push) wptr_n = wptr + 1'b1;
      if (pop)  rptr_n = rptr + 1'b1;
      if (push && !pop)      count_n = count + 1'b1;
      else if (!push && pop) count_n = count - 1'b1;
    end

    if (jump_valid) pc_n = jump_addr;

    // Issue gates on the post-push/pop occupancy so the response always has a slot.
    case (state)
      RUN: begin
        if (fence_take) begin
          state_n = FENCE_DRAIN;
        end else if (!jump_valid && (!pending || itim_out.mem_ready) &&
                     (count_n < CW'(buffer_depth))) begin
          issue     = 1'b1;
          pending_n = 1'b1;
          req_pc_n  = pc;
          pc_n      = pc + 32'd4;
        end
      end
      FENCE_DRAIN: begin
        if (!jump_valid && !pending) begin
          issue       = 1'b1;
          issue_fence = 1'b1;
          fcnt_n      = FW'(fence_cycles);
          state_n     = FENCE_WAIT;
        end
      end
      FENCE_WAIT: begin
        fcnt_n = fcnt - 1'b1;
        if (fcnt == FW'(1)) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
    else        state <= state_n;
  end

  // Control and request registers; request fields are zero when not valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc          <= start_addr;
      req_pc      <= '0;
      pending     <= 1'b0;
      drop        <= 1'b0;
      fcnt        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      mem_valid_q <= 1'b0;
      mem_fence_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      pc          <= pc_n;
      req_pc      <= req_pc_n;
      pending     <= pending_n;
      drop        <= drop_n;
      fcnt        <= fcnt_n;
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count       <= count_n;
      mem_valid_q <= issue;
      mem_fence_q <= issue_fence;
      mem_addr_q  <= issue ? pc : '0;
    end
  end

  // FIFO storage; contents are only observable through a non-empty head.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      buf_pc[wptr]   <= req_pc;
      buf_data[wptr] <= itim_out.mem_rdata;
    end
  end

  // Decode-side outputs, forced to zero while the FIFO is empty.
  always_comb begin
    instr_valid = (count != '0);
    instr_pc    = instr_valid ? buf_pc[rptr]   : '0;
    instr_data  = instr_valid ? buf_data[rptr] : '0;
  end

  // TIM request bundle.
  always_comb begin
    itim_in           = '0;
    itim_in.mem_valid = mem_valid_q;
    itim_in.mem_instr = 1'b1;
    itim_in.mem_fence = mem_fence_q;
    itim_in.mem_addr  = mem_addr_q;
    itim_in.mem_wdata = '0;
    itim_in.mem_wstrb = '0;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a behavioural TIM with programmable latency plus
// request and instruction scoreboards, driven from one sequential process.

module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int ITIM_DEPTH = 4;
  localparam int FC         = ITIM_DEPTH + 2;

  logic        clock;
  logic        reset;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        fence_valid;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_data;
  mem_in_type  itim_in;
  mem_out_type itim_out;

  fetch_buffer #(
    .buffer_depth(4),
    .start_addr  (32'h0),
    .itim_depth  (ITIM_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .fence_valid(fence_valid),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr_pc   (instr_pc),
    .instr_data (instr_data),
    .itim_in    (itim_in),
    .itim_out   (itim_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_req_q   [$];
  logic        exp_fence_q [$];
  logic [31:0] exp_instr_q [$];
  bit          mon_on, req_strict, chk_spacing;
  int          tim_lat, tim_rem;
  logic [31:0] tim_addr;
  int          last_req_cyc, fence_cnt, fence_cyc, post_fence_cyc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic push_req(input logic [31:0] a, input logic f);
    exp_req_q.push_back(a);
    exp_fence_q.push_back(f);
  endtask

  // Per-cycle observation at the falling edge, then the TIM model update.
  task automatic observe();
    logic [31:0] e_addr, e_pc;
    logic        e_fence;
    if (mon_on) begin
      if (itim_in.mem_valid) begin
        if (exp_req_q.size() != 0) begin
          e_addr  = exp_req_q.pop_front();
          e_fence = exp_fence_q.pop_front();
          n_checks++;
          if (itim_in.mem_addr !== e_addr || itim_in.mem_fence !== e_fence) begin
            n_fail++;
            $display("FAIL req: got addr %h fence %b, expected addr %h fence %b",
                     itim_in.mem_addr, itim_in.mem_fence, e_addr, e_fence);
          end
        end else if (req_strict) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_extra: got request to %h, expected none", itim_in.mem_addr);
        end
        if (chk_spacing && last_req_cyc >= 0) begin
          n_checks++;
          if (cyc - last_req_cyc != 2) begin
            n_fail++;
            $display("FAIL req_spacing: got %0d cycles, expected 2", cyc - last_req_cyc);
          end
        end
        last_req_cyc = cyc;
        if (itim_in.mem_fence) begin
          fence_cnt++;
          fence_cyc = cyc;
        end else if (fence_cyc >= 0 && post_fence_cyc < 0) begin
          post_fence_cyc = cyc;
        end
      end else begin
        n_checks++;
        if (itim_in.mem_addr !== 32'h0 || itim_in.mem_fence !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_fields: got addr %h fence %b, expected 0 0",
                   itim_in.mem_addr, itim_in.mem_fence);
        end
      end
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_instr_q.size() == 0) begin
          n_fail++;
          $display("FAIL instr_extra: got pc %h, expected none", instr_pc);
        end else begin
          e_pc = exp_instr_q.pop_front();
          if (instr_pc !== e_pc || instr_data !== word_of(e_pc)) begin
            n_fail++;
            $display("FAIL instr: got pc %h data %h, expected pc %h data %h",
                     instr_pc, instr_data, e_pc, word_of(e_pc));
          end
        end
      end
    end
    if (!reset) begin
      tim_rem  = 0;
      itim_out = '0;
    end else begin
      itim_out = '0;
      if (tim_rem > 0) begin
        tim_rem--;
        if (tim_rem == 0) begin
          itim_out.mem_ready = 1'b1;
          itim_out.mem_rdata = word_of(tim_addr);
        end
      end
      if (itim_in.mem_valid && !itim_in.mem_fence) begin
        n_checks++;
        if (tim_rem != 0 || itim_out.mem_ready) begin
          n_fail++;
          $display("FAIL overlap: got new request %h while one outstanding, expected none",
                   itim_in.mem_addr);
        end
        tim_rem  = tim_lat;
        tim_addr = itim_in.mem_addr;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      observe();
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    mon_on      = 1'b0;
    req_strict  = 1'b0;
    chk_spacing = 1'b0;
    reset       = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
    fence_valid = 1'b0;
    instr_ready = 1'b0;
    step(2);
    exp_req_q.delete();
    exp_fence_q.delete();
    exp_instr_q.delete();
    last_req_cyc   = -1;
    fence_cnt      = 0;
    fence_cyc      = -1;
    post_fence_cyc = -1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_instr_q.size() != 0; i++) step(1);
    n_checks++;
    if (exp_instr_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_instr_left: got %0d undelivered, expected 0", name, exp_instr_q.size());
    end
    n_checks++;
    if (exp_req_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_req_left: got %0d unissued, expected 0", name, exp_req_q.size());
    end
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got v %b pc %h d %h, expected 0 0 0", instr_valid, instr_pc, instr_data);
    end
    n_checks++;
    if (itim_in.mem_valid !== 1'b0 || itim_in.mem_addr !== 32'h0 || itim_in.mem_fence !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got v %b a %h f %b, expected 0 0 0",
               itim_in.mem_valid, itim_in.mem_addr, itim_in.mem_fence);
    end
    n_checks++;
    if (itim_in.mem_instr !== 1'b1 || itim_in.mem_wdata !== 32'h0 || itim_in.mem_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL const_fields: got instr %b wdata %h wstrb %h, expected 1 0 0",
               itim_in.mem_instr, itim_in.mem_wdata, itim_in.mem_wstrb);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tim_lat     = 1;
    instr_ready = 1'b1;
    chk_spacing = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_req(32'(i * 4), 1'b0);
      exp_instr_q.push_back(32'(i * 4));
    end
    mon_on = 1'b1;
    reset  = 1'b1;
    wait_drain(60, "stream");
  endtask

  task automatic test_backpressure();
    do_reset();
    tim_lat    = 1;
    req_strict = 1'b1;
    for (int i = 0; i < 4; i++) push_req(32'(i * 4), 1'b0);
    mon_on = 1'b1;
    reset  = 1'b1;
    step(20);
    n_checks++;
    if (exp_req_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d requests missing, expected 0", exp_req_q.size());
    end
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== word_of(32'h0) ||
        itim_in.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got v %b pc %h d %h mv %b, expected 1 0 %h 0",
               instr_valid, instr_pc, instr_data, itim_in.mem_valid, word_of(32'h0));
    end
    push_req(32'h10, 1'b0);
    exp_instr_q.push_back(32'h0);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(6);
    n_checks++;
    if (exp_req_q.size() != 0 || exp_instr_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_one_more: got %0d req %0d instr pending, expected 0 0",
               exp_req_q.size(), exp_instr_q.size());
    end
    n_checks++;
    if (instr_pc !== 32'h4 || instr_data !== word_of(32'h4)) begin
      n_fail++;
      $display("FAIL bp_head: got pc %h d %h, expected 4 %h", instr_pc, instr_data, word_of(32'h4));
    end
    mon_on = 1'b0;
  endtask

  task automatic test_jump_pending();
    do_reset();
    tim_lat = 5;
    push_req(32'h0, 1'b0);
    push_req(32'h4, 1'b0);
    mon_on = 1'b1;
    reset  = 1'b1;
    step(9);
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jp_before: got instr_valid %b, expected 1", instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      push_req(32'h100 + 32'(i * 4), 1'b0);
      exp_instr_q.push_back(32'h100 + 32'(i * 4));
    end
    jump_valid = 1'b1;
    jump_addr  = 32'h100;
    step(1);
    jump_valid  = 1'b0;
    tim_lat     = 1;
    instr_ready = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0 || itim_in.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jp_flush: got instr_valid %b mem_valid %b, expected 0 0",
               instr_valid, itim_in.mem_valid);
    end
    wait_drain(80, "jump_pending");
  endtask

  task automatic test_jump_ready();
    do_reset();
    tim_lat     = 1;
    instr_ready = 1'b1;
    push_req(32'h0, 1'b0);
    push_req(32'h4, 1'b0);
    exp_instr_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      push_req(32'h200 + 32'(i * 4), 1'b0);
      exp_instr_q.push_back(32'h200 + 32'(i * 4));
    end
    mon_on = 1'b1;
    reset  = 1'b1;
    step(4);
    jump_valid = 1'b1;
    jump_addr  = 32'h200;
    step(1);
    jump_valid = 1'b0;
    wait_drain(60, "jump_ready");
  endtask

  task automatic check_fence_gap(input string name);
    n_checks++;
    if (fence_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_count: got %0d fence requests, expected 1", name, fence_cnt);
    end
    n_checks++;
    if (post_fence_cyc - fence_cyc != FC + 1) begin
      n_fail++;
      $display("FAIL %s_gap: got %0d cycles fence-to-next, expected %0d",
               name, post_fence_cyc - fence_cyc, FC + 1);
    end
  endtask

  task automatic test_fence();
    do_reset();
    tim_lat     = 3;
    instr_ready = 1'b1;
    push_req(32'h0, 1'b0);
    push_req(32'h4, 1'b1);
    for (int i = 1; i < 4; i++) begin
      push_req(32'(i * 4), 1'b0);
      exp_instr_q.push_back(32'(i * 4));
    end
    mon_on = 1'b1;
    reset  = 1'b1;
    step(2);
    fence_valid = 1'b1;
    step(1);
    fence_valid = 1'b0;
    wait_drain(80, "fence");
    check_fence_gap("fence");
  endtask

  task automatic test_jump_fence();
    do_reset();
    tim_lat     = 1;
    instr_ready = 1'b1;
    push_req(32'h0, 1'b0);
    push_req(32'h4, 1'b0);
    push_req(32'h300, 1'b1);
    exp_instr_q.push_back(32'h0);
    for (int i = 0; i < 2; i++) begin
      push_req(32'h300 + 32'(i * 4), 1'b0);
      exp_instr_q.push_back(32'h300 + 32'(i * 4));
    end
    mon_on = 1'b1;
    reset  = 1'b1;
    step(4);
    jump_valid  = 1'b1;
    jump_addr   = 32'h300;
    fence_valid = 1'b1;
    step(1);
    jump_valid  = 1'b0;
    fence_valid = 1'b0;
    wait_drain(80, "jump_fence");
    check_fence_gap("jump_fence");
  endtask

  task automatic test_reset_mid();
    do_reset();
    tim_lat = 1;
    for (int i = 0; i < 4; i++) push_req(32'(i * 4), 1'b0);
    mon_on = 1'b1;
    reset  = 1'b1;
    step(6);
    tim_lat = 8;
    step(2);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || exp_req_q.size() != 0) begin
      n_fail++;
      $display("FAIL rm_before: got v %b pc %h req_left %0d, expected 1 0 0",
               instr_valid, instr_pc, exp_req_q.size());
    end
    reset = 1'b0;
    step(1);
    n_checks++;
    if (instr_valid !== 1'b0 || itim_in.mem_valid !== 1'b0 || instr_pc !== 32'h0 ||
        instr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_after: got v %b mv %b pc %h d %h, expected 0 0 0 0",
               instr_valid, itim_in.mem_valid, instr_pc, instr_data);
    end
    push_req(32'h0, 1'b0);
    push_req(32'h4, 1'b0);
    exp_instr_q.push_back(32'h0);
    exp_instr_q.push_back(32'h4);
    tim_lat     = 1;
    instr_ready = 1'b1;
    reset       = 1'b1;
    wait_drain(40, "reset_mid");
  endtask

  initial begin
    reset       = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
    fence_valid = 1'b0;
    instr_ready = 1'b0;
    itim_out    = '0;
    tim_lat     = 1;
    tim_rem     = 0;
    tim_addr    = '0;
    mon_on      = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_pending();
    test_jump_ready();
    test_fence();
    test_jump_fence();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
